// File: rtl/dtw_pkg.sv
// Shared types and constants for the DTW gesture-to-word front end.
// Holds character codes, word geometry and state encodings.
package dtw_pkg;

    localparam int CHAR_W    = 8;
    localparam int MAX_CHARS = 15;
    localparam int WORD_W    = CHAR_W * MAX_CHARS;
    localparam int LEN_W     = $clog2(MAX_CHARS + 1);

    localparam logic [CHAR_W-1:0] CH_NUL = 8'h00;
    localparam logic [CHAR_W-1:0] CH_BS  = 8'h08;
    localparam logic [CHAR_W-1:0] CH_SP  = 8'h20;
    localparam logic [CHAR_W-1:0] CH_LF  = 8'h0A;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_START   = 2'd1,
        S_WAIT    = 2'd2,
        S_OUTPUT  = 2'd3
    } asm_state_e;

    typedef enum logic [2:0] {
        CLS_GAP    = 3'd0,
        CLS_LETTER = 3'd1,
        CLS_BS     = 3'd2,
        CLS_TERM   = 3'd3,
        CLS_OTHER  = 3'd4
    } char_cls_e;

    // Matcher state codes, so debug tooling can decode both blocks.
    localparam logic [1:0] DTW_S_IDLE = 2'd0;
    localparam logic [1:0] DTW_S_LOAD = 2'd1;
    localparam logic [1:0] DTW_S_SCAN = 2'd2;
    localparam logic [1:0] DTW_S_DONE = 2'd3;

endpackage

// File: rtl/dtw_word_assembler_char_filter.sv
// Classifies a raw classifier character and folds lowercase to uppercase.
module dtw_char_filter
    import dtw_pkg::*;
(
    input  logic [CHAR_W-1:0] char_i,
    output char_cls_e         cls_o,
    output logic [CHAR_W-1:0] upper_o
);

    always_comb begin
        cls_o   = CLS_OTHER;
        upper_o = char_i;
        if (char_i == CH_NUL) begin
            cls_o = CLS_GAP;
        end else if (char_i >= 8'h61 && char_i <= 8'h7A) begin
            cls_o   = CLS_LETTER;
            upper_o = char_i - 8'h20;
        end else if (char_i >= 8'h41 && char_i <= 8'h5A) begin
            cls_o = CLS_LETTER;
        end else if (char_i == CH_BS) begin
            cls_o = CLS_BS;
        end else if (char_i == CH_SP || char_i == CH_LF) begin
            cls_o = CLS_TERM;
        end
    end

endmodule

// File: rtl/dtw_word_assembler.sv
// Builds a packed word from the glove character stream, runs the DTW
// matcher on it and hands the matched (or fallback) word downstream.
module dtw_word_assembler
    import dtw_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              i_DTW_clk,
    input  logic              i_DTW_rst_n,
    input  logic              i_char_valid,
    input  logic [CHAR_W-1:0] i_char,
    output logic              o_char_ready,
    output logic              o_DTW_start,
    output logic [WORD_W-1:0] o_DTW_word,
    input  logic              i_DTW_finish,
    input  logic [WORD_W-1:0] i_DTW_result,
    output logic              o_result_valid,
    output logic [WORD_W-1:0] o_result_word,
    input  logic              i_result_ready,
    output logic [LEN_W-1:0]  o_length,
    output logic              o_overflow,
    output logic              o_timeout,
    output logic [1:0]        o_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    asm_state_e state_q, state_d;
    logic [MAX_CHARS-1:0][CHAR_W-1:0] buf_q, buf_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [CHAR_W-1:0] last_q, last_d;
    logic              lastv_q, lastv_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] res_q, res_d;
    logic              tmo_q, tmo_d;

    char_cls_e         cls;
    logic [CHAR_W-1:0] upper;

    dtw_char_filter u_filter (
        .char_i  (i_char),
        .cls_o   (cls),
        .upper_o (upper)
    );

    always_ff @(posedge i_DTW_clk or negedge i_DTW_rst_n) begin
        if (!i_DTW_rst_n) begin
            state_q <= S_COLLECT;
            buf_q   <= '0;
            len_q   <= '0;
            last_q  <= '0;
            lastv_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            last_q  <= last_d;
            lastv_q <= lastv_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        len_d   = len_q;
        last_d  = last_q;
        lastv_d = lastv_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            S_COLLECT: begin
                // A held gesture repeats its letter; only the first counts.
                if (i_char_valid &&
                    !(cls == CLS_LETTER && lastv_q && upper == last_q)) begin
                    unique case (cls)
                        CLS_GAP: lastv_d = 1'b0;
                        CLS_LETTER: begin
                            last_d  = upper;
                            lastv_d = 1'b1;
                            if (len_q < LEN_W'(MAX_CHARS)) begin
                                buf_d[len_q] = upper;
                                len_d        = len_q + 1'b1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                        CLS_BS: begin
                            lastv_d = 1'b0;
                            if (len_q != '0) begin
                                buf_d[len_q - 1'b1] = '0;
                                len_d               = len_q - 1'b1;
                            end
                        end
                        CLS_TERM: begin
                            lastv_d = 1'b0;
                            if (len_q != '0) state_d = S_START;
                        end
                        default: ;
                    endcase
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_DTW_finish) begin
                    res_d   = i_DTW_result;
                    tmo_d   = 1'b0;
                    state_d = S_OUTPUT;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    res_d   = buf_q;
                    tmo_d   = 1'b1;
                    state_d = S_OUTPUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_OUTPUT: begin
                if (i_result_ready) begin
                    buf_d   = '0;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    lastv_d = 1'b0;
                    state_d = S_COLLECT;
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

    assign o_char_ready   = (state_q == S_COLLECT);
    assign o_DTW_start    = (state_q == S_START);
    assign o_result_valid = (state_q == S_OUTPUT);
    assign o_DTW_word     = buf_q;
    assign o_result_word  = res_q;
    assign o_length       = len_q;
    assign o_overflow     = ovf_q;
    assign o_timeout      = tmo_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_dtw_word_assembler.sv
// Scoreboard bench for dtw_word_assembler: directed character vectors,
// expected start words and results queued, monitors compare on output.
module tb_dtw_word_assembler;
    import dtw_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              char_valid = 1'b0;
    logic [7:0]        char_in = '0;
    logic              char_ready;
    logic              dtw_start;
    logic [WORD_W-1:0] dtw_word;
    logic              dtw_finish = 1'b0;
    logic [WORD_W-1:0] dtw_result = '0;
    logic              res_valid;
    logic [WORD_W-1:0] res_word;
    logic              res_ready = 1'b0;
    logic [3:0]        length;
    logic              overflow;
    logic              timeout;
    logic [1:0]        state;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [WORD_W-1:0] word;
        logic              tmo;
    } res_t;

    logic [WORD_W-1:0] start_q[$];
    res_t              res_q[$];

    localparam logic [WORD_W-1:0] W_HI  = 120'h4948;
    localparam logic [WORD_W-1:0] W_CAR = 120'h524143;
    localparam logic [WORD_W-1:0] W_X   = 120'h58;
    localparam logic [WORD_W-1:0] W_AB15 =
        120'h414241424142414241424142414241;
    localparam logic [WORD_W-1:0] W_BOGUS = 120'hFFFF_FFFF;
    localparam logic [WORD_W-1:0] W_OK  = 120'h4B4F;

    dtw_word_assembler #(.TIMEOUT_CYCLES(16)) dut (
        .i_DTW_clk      (clk),
        .i_DTW_rst_n    (rst_n),
        .i_char_valid   (char_valid),
        .i_char         (char_in),
        .o_char_ready   (char_ready),
        .o_DTW_start    (dtw_start),
        .o_DTW_word     (dtw_word),
        .i_DTW_finish   (dtw_finish),
        .i_DTW_result   (dtw_result),
        .o_result_valid (res_valid),
        .o_result_word  (res_word),
        .i_result_ready (res_ready),
        .o_length       (length),
        .o_overflow     (overflow),
        .o_timeout      (timeout),
        .o_state        (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start monitor: every start pulse must match a queued word.
    always @(negedge clk) begin
        if (rst_n && dtw_start) begin
            if (start_q.size() == 0) begin
                chk("unexpected_start", 1, 0);
            end else begin
                chk("start_word", dtw_word, start_q.pop_front());
            end
        end
    end

    // Result monitor: compare on each handshake.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (res_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                res_t e;
                e = res_q.pop_front();
                chk("result_word", res_word, e.word);
                chk("result_timeout", timeout, e.tmo);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic send(input logic [7:0] c);
        char_in    = c;
        char_valid = 1'b1;
        @(posedge clk); #1;
        char_valid = 1'b0;
        char_in    = '0;
    endtask

    task automatic send_term_check();
        send(8'h20);
        @(negedge clk);
        chk("start_high", dtw_start, 1);
        @(negedge clk);
        chk("start_one_cycle", dtw_start, 0);
        chk("in_wait", state, 2);
        chk("ready_low_wait", char_ready, 0);
    endtask

    task automatic finish_with(input logic [WORD_W-1:0] w);
        @(posedge clk); #1;
        dtw_finish = 1'b1;
        dtw_result = w;
        @(posedge clk); #1;
        dtw_finish = 1'b0;
        dtw_result = '0;
    endtask

    task automatic accept();
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk("post_accept_state", state, 0);
        chk("post_accept_len", length, 0);
        chk("post_accept_word", dtw_word, 0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_ready", char_ready, 1);
        chk("rst_outs", {dtw_start, res_valid, overflow, timeout, length}, 0);
        chk("rst_word", dtw_word, 0);
        chk("rst_result", res_word, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Held-gesture dedupe and gap.
        send("H"); send("H"); send("H"); send(8'h00); send("I");
        @(negedge clk);
        chk("hi_len", length, 2);
        start_q.push_back(W_HI);
        send_term_check();
        res_q.push_back('{W_CAR, 1'b0});
        finish_with(W_CAR);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("valid_held", res_valid, 1);
            chk("ready_low_out", char_ready, 0);
        end
        accept();

        // Lowercase fold and backspace, then matcher timeout.
        send("c"); send("a"); send("t"); send(8'h08); send("r");
        @(negedge clk);
        chk("car_len", length, 3);
        chk("car_word", dtw_word, W_CAR);
        start_q.push_back(W_CAR);
        res_q.push_back('{W_CAR, 1'b1});
        send_term_check();
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid) break;
            if (state == 2'd2) n++;
        end
        chk("timeout_cycles", n, 16);
        chk("timeout_flag", timeout, 1);
        finish_with(W_BOGUS);
        accept();

        // Overflow past capacity.
        for (int i = 0; i < 17; i++) send((i % 2 == 0) ? "A" : "B");
        @(negedge clk);
        chk("ovf_len", length, 15);
        chk("ovf_flag", overflow, 1);
        start_q.push_back(W_AB15);
        res_q.push_back('{W_OK, 1'b0});
        send_term_check();
        finish_with(W_OK);
        accept();
        chk("ovf_cleared", overflow, 0);

        // Ignored codes, dedupe across them, backspace at empty.
        send("D"); send(8'h31); send("D"); send("d");
        @(negedge clk);
        chk("other_keeps_dedupe", length, 1);
        send(8'h00); send("d");
        @(negedge clk);
        chk("gap_allows_repeat", length, 2);
        send(8'h08); send(8'h08); send(8'h08);
        @(negedge clk);
        chk("bs_floor", length, 0);
        send(8'h20);
        send(8'h0A);
        @(negedge clk);
        chk("empty_term_no_start", state, 0);

        // Reset during matcher wait.
        send("X");
        start_q.push_back(W_X);
        send_term_check();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_state", state, 0);
        chk("midrst_outs", {res_valid, overflow, timeout, length}, 0);
        chk("midrst_word", dtw_word, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        finish_with(W_BOGUS);
        repeat (3) begin
            @(negedge clk);
            chk("finish_ignored", {res_valid, state}, 0);
        end
        chk("result_kept_clear", res_word, 0);

        repeat (3) @(negedge clk);
        chk("start_q_drained", start_q.size(), 0);
        chk("res_q_drained", res_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dtw_word_assembler.md
Name: dtw_word_assembler

Overview:
- Upstream stage of the DTW matcher.
- Collects the per-gesture character stream from the glove classifier into a packed 15-byte word.
- Collapses repeated characters emitted while a gesture is held and handles backspace and word terminators.
- Launches the DTW matcher, holds its word input stable, then presents the matched word downstream through a valid/ready handshake.

Parameters:
CHAR_W, 8, bits per character
MAX_CHARS, 15, word capacity in characters (WORD_W = CHAR_W*MAX_CHARS = 120)
TIMEOUT_CYCLES, 4096, max cycles to wait for DTW finish before fallback

Ports:
i_DTW_clk  in  1  clock
i_DTW_rst_n  in  1  reset
i_char_valid  in  1  classifier character valid
i_char  in  8  ASCII character from classifier
o_char_ready  out  1  high only in S_COLLECT
o_DTW_start  out  1  one-cycle start pulse to matcher
o_DTW_word  out  120  packed word; char k at bits [8k+7:8k], char 0 = first letter, unused bytes 0x00
i_DTW_finish  in  1  one-cycle matcher done pulse
i_DTW_result  in  120  matched word, sampled on i_DTW_finish
o_result_valid  out  1  matched word available
o_result_word  out  120  matched (or fallback) word
i_result_ready  in  1  downstream accepts result
o_length  out  4  current character count
o_overflow  out  1  sticky: a letter was dropped because the word was full
o_timeout  out  1  result is the fallback (matcher timed out)
o_state  out  2  current FSM state, for debug

Behaviour:
- Reset: i_DTW_rst_n, asynchronous, active-low; clock i_DTW_clk.
- Reset values:
  - state = S_COLLECT.
  - All outputs 0; buffer, length, last_char, last_valid, timeout counter and result register all 0.
  - o_char_ready = 1 after reset, since it is decoded from state.
- A reset asserted mid-operation aborts everything and discards the partial word and any pending result.
- States: S_COLLECT=0, S_START=1, S_WAIT=2, S_OUTPUT=3.
- S_COLLECT: a character is accepted on i_char_valid & o_char_ready. Character classes:
  - 0x00 (gap): clear last_valid; nothing stored.
  - Equal to last_char while last_valid=1: dropped (dedupe). This takes priority over every class below.
  - 0x61-0x7A: folded to uppercase (minus 0x20) before the dedupe compare and store.
  - 0x41-0x5A:
    - If length < MAX_CHARS: write byte[length], length+1, last_char = char, last_valid = 1.
    - Otherwise: drop the letter, set o_overflow, and still update last_char.
  - 0x08 (backspace): if length > 0, zero byte[length-1] and length-1; clear last_valid. If length = 0, no effect.
  - 0x20 or 0x0A (terminator): if length > 0, go to S_START. If length = 0, ignore. Clears last_valid.
  - Any other code: ignored and leaves last_valid unchanged.
- S_START:
  - o_DTW_start = 1 for exactly this one cycle.
  - Latency: a terminator accepted in cycle N gives start high in cycle N+1.
  - Clear the timeout counter, then go to S_WAIT.
- S_WAIT:
  - o_DTW_word is held stable from S_START until the return to S_COLLECT.
  - On i_DTW_finish: register i_DTW_result into o_result_word, set o_timeout = 0, go to S_OUTPUT. o_result_valid rises the following cycle.
  - Otherwise increment the counter. When it reaches TIMEOUT_CYCLES-1 without finish, set o_result_word = o_DTW_word, set o_timeout = 1, and go to S_OUTPUT.
  - If finish and timeout occur in the same cycle, finish wins.
- i_DTW_finish is ignored in every state except S_WAIT.
- S_OUTPUT:
  - o_result_valid = 1, held with o_result_word stable until i_result_ready is high.
  - On the accept cycle: clear the buffer, length, o_overflow and last_valid; return to S_COLLECT.
  - o_timeout holds until the next result is registered.
- Input characters are never accepted outside S_COLLECT (ready = 0). The upstream source must hold or drop them.
- Width rules: length saturates at MAX_CHARS; the counter width is $clog2(TIMEOUT_CYCLES).

Decomposition:
- Package dtw_pkg:
  - CHAR_W, MAX_CHARS, WORD_W.
  - Character constants: CH_NUL, CH_BS, CH_SP, CH_LF.
  - The state enum for this block.
  - The S_* encodings of the matcher, for shared debug decode.
- Sub-module dtw_char_filter: combinational.
  - Input: a raw character.
  - Outputs: the class (gap/letter/backspace/terminator/other) and the uppercase-folded letter.

Test Plan:
- Send "H","H","H",0x00,"I"," " → stored "HI" (byte0=0x48, byte1=0x49, rest 0); length 2; o_DTW_start high exactly one cycle, one cycle after the space is accepted.
- Send "c","a","t",0x08,"r"," " → o_DTW_word bytes 0x43,0x41,0x52; the byte[2] write after backspace is correct; length 3.
- Send 17 distinct alternating letters then " " → length 15; o_overflow = 1; bytes 15 and 16 absent; start issued.
- After start, assert i_DTW_finish with result "CAR" 3 cycles later, holding i_result_ready low for 5 cycles:
  - o_result_valid rises the cycle after finish and holds 5 cycles.
  - o_result_word = "CAR"; o_char_ready stays 0 until the accept.
- Never pulse finish (TIMEOUT_CYCLES=16) → after 16 cycles in S_WAIT, o_result_word equals the input word and o_timeout = 1.
- Assert reset during S_WAIT → next cycle: all outputs 0, state S_COLLECT. A later finish pulse is ignored.
- Send a space with length 0 → no start.
